adc_sample_packer: RTL and testbench

ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

---
 rtl/adc_sample_packer.sv | 143 ++++++++++++++
 tb/tb_adc_sample_packer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_packer.sv
// -----------------------------------------------------------------------------
// adc_sample_packer
//
// Packs ADC samples into a byte stream. Samples are appended MSB-first into a
// 24-bit staging register; whenever at least 8 bits are pending, the top byte
// is presented on the output handshake. Three packing modes are supported:
//   00 / 11 : 8-bit   - top 8 bits of each sample
//   01      : 12-bit  - sample left-aligned to 12 bits, two samples -> 3 bytes
//   10      : 16-bit  - sample zero-extended to 16 bits, one sample -> 2 bytes
//
// Ports
//   clk_usb      in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   mode         in   packing mode, taken only while the packer is empty
//   in_data      in   ADC sample (pSAMPLE_WIDTH bits)
//   in_valid     in   in_data valid
//   in_ready     out  a sample would fit in the staging register
//   out_byte     out  top 8 staged bits
//   out_valid    out  at least 8 bits pending
//   out_ready    in   consumer takes out_byte this cycle
//   flush        in   pad a 4-bit residue with a zero nibble to a full byte
//   clear_count  in   synchronous clear of byte_count (wins over a pop)
//   byte_count   out  bytes emitted, saturating
//   idle         out  no pending bits
// -----------------------------------------------------------------------------
module adc_sample_packer #(
   parameter int pSAMPLE_WIDTH = 12,
   parameter int pCOUNT_WIDTH  = 16
) (
   input  logic                     clk_usb,
   input  logic                     reset_n,
   input  logic [1:0]               mode,
   input  logic [pSAMPLE_WIDTH-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [7:0]               out_byte,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     flush,
   input  logic                     clear_count,
   output logic [pCOUNT_WIDTH-1:0]  byte_count,
   output logic                     idle
);

   localparam logic [1:0] MODE_12 = 2'b01;
   localparam logic [1:0] MODE_16 = 2'b10;

   // Zero fill needed to left-align a narrower sample to 12 bits.
   localparam int LSB_PAD = 12 - pSAMPLE_WIDTH;

   logic [23:0] stage_r;     // pending bits occupy the top pend_r bits, rest zero
   logic [4:0]  pend_r;      // pending-bit count, 0..24 in steps of 4
   logic [1:0]  mode_r;

   logic [4:0]  bits_per_sample;
   logic [23:0] payload_al;  // payload left-aligned in a 24-bit word
   logic [11:0] payload_12;
   logic [15:0] payload_16;
   logic        accept;
   logic        pop;
   logic [23:0] stage_pop;
   logic [4:0]  pend_pop;
   logic [23:0] stage_nxt;
   logic [4:0]  pend_nxt;

   assign payload_12 = 12'(in_data) << LSB_PAD;
   assign payload_16 = 16'(in_data);

   // NOTE: every variable driven here gets a default first, so no path through
   // the block can leave it unassigned and infer a latch.
   always_comb begin
      bits_per_sample = 5'd8;
      payload_al      = {in_data[pSAMPLE_WIDTH-1 -: 8], 16'h0000};
      case (mode_r)
         MODE_12: begin
            bits_per_sample = 5'd12;
            payload_al      = {payload_12, 12'h000};
         end
         MODE_16: begin
            bits_per_sample = 5'd16;
            payload_al      = {payload_16, 8'h00};
         end
         default: ;
      endcase
   end

   // Readiness looks only at registered state; a same-cycle pop is not counted,
   // which still sustains one byte per cycle in every mode.
   assign in_ready  = ({1'b0, pend_r} + {1'b0, bits_per_sample}) <= 6'd24;
   assign out_valid = pend_r >= 5'd8;
   assign out_byte  = stage_r[23:16];
   assign idle      = pend_r == 5'd0;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // Pop first, then append the new payload directly below what remains, then
   // round a 4-bit residue up on flush. The bits below the pending ones are
   // always zero, so OR-ing the shifted payload in is enough and the flush
   // nibble comes out zero for free.
   always_comb begin
      stage_pop = pop ? {stage_r[15:0], 8'h00} : stage_r;
      pend_pop  = pop ? pend_r - 5'd8 : pend_r;
      stage_nxt = stage_pop;
      pend_nxt  = pend_pop;
      if (accept) begin
         stage_nxt = stage_pop | (payload_al >> pend_pop);
         pend_nxt  = pend_pop + bits_per_sample;
      end
      if (flush && pend_nxt[2]) begin
         pend_nxt = pend_nxt + 5'd4;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n) begin
         stage_r <= '0;
         pend_r  <= '0;
         mode_r  <= 2'b00;
      end else begin
         stage_r <= stage_nxt;
         pend_r  <= pend_nxt;
         // A mode change only takes hold once the packer is empty, so a
         // partly packed word is never reinterpreted.
         if (pend_r == 5'd0 && !accept) begin
            mode_r <= mode;
         end
      end
   end

   always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n) begin
         byte_count <= '0;
      end else if (clear_count) begin
         byte_count <= '0;
      end else if (pop && byte_count != '1) begin
         byte_count <= byte_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_sample_packer.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_packer
//
// Self-checking bench for adc_sample_packer (12-bit samples, 6-bit byte
// counter so saturation is reachable). The reference model keeps the pending
// data as a plain queue of bits: samples are appended bit by bit, bytes are
// taken from the front, and flush pads a 4-bit residue with zeros.
// -----------------------------------------------------------------------------
module tb_adc_sample_packer;

   localparam int W    = 12;
   localparam int CW   = 6;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk_usb;
   logic          reset_n;
   logic [1:0]    mode;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_byte;
   logic          out_valid;
   logic          out_ready;
   logic          flush;
   logic          clear_count;
   logic [CW-1:0] byte_count;
   logic          idle;

   adc_sample_packer #(
      .pSAMPLE_WIDTH (W),
      .pCOUNT_WIDTH  (CW)
   ) dut (
      .clk_usb     (clk_usb),
      .reset_n     (reset_n),
      .mode        (mode),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_byte    (out_byte),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .flush       (flush),
      .clear_count (clear_count),
      .byte_count  (byte_count),
      .idle        (idle)
   );

   initial begin
      clk_usb = 1'b0;
      forever #5 clk_usb = ~clk_usb;
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model state
   bit         m_q[$];
   logic [1:0] m_mode;
   int         m_count;
   logic [7:0] exp_q[$];

   // Observed output stream
   logic [7:0] got_q[$];
   int         got_cyc[$];

   function automatic int m_bits();
      case (m_mode)
         2'b01:   return 12;
         2'b10:   return 16;
         default: return 8;
      endcase
   endfunction

   function automatic bit m_ready();
      return (m_q.size() + m_bits()) <= 24;
   endfunction

   function automatic logic [7:0] m_front_byte();
      int v = 0;
      for (int k = 0; k < 8; k++) begin
         v = (v << 1) | ((k < m_q.size()) ? int'(m_q[k]) : 0);
      end
      return 8'(v);
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_mode  = 2'b00;
      m_count = 0;
   endtask

   // Called at the falling edge with inputs settled: records the DUT output
   // transfer, advances the model by one clock, and steps to the next falling edge.
   task automatic tick();
      int   sz;
      int   b;
      bit   acc;
      bit   pp;
      int   pv;
      bit   dummy;
      sz  = m_q.size();
      b   = m_bits();
      acc = in_valid && ((sz + b) <= 24);
      pp  = (sz >= 8) && out_ready;
      if (out_valid && out_ready) begin
         got_q.push_back(out_byte);
         got_cyc.push_back(cyc);
      end
      if (pp) begin
         exp_q.push_back(m_front_byte());
         for (int k = 0; k < 8; k++) dummy = m_q.pop_front();
      end
      if (clear_count) m_count = 0;
      else if (pp && m_count < CMAX) m_count++;
      if (acc) begin
         pv = (m_mode == 2'b01 || m_mode == 2'b10) ? int'(in_data) : int'(in_data) >> 4;
         for (int k = b - 1; k >= 0; k--) m_q.push_back(bit'((pv >> k) & 1));
      end
      if (flush && (m_q.size() % 8) == 4) begin
         for (int k = 0; k < 4; k++) m_q.push_back(1'b0);
      end
      if (sz == 0 && !acc) m_mode = mode;
      cyc++;
      @(posedge clk_usb);
      @(negedge clk_usb);
   endtask

   task automatic push(input logic [W-1:0] s);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_data  = s;
      for (int i = 0; i < 64 && !done; i++) begin
         done = in_ready;
         tick();
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL push_timeout: sample %h not accepted, in_ready %b expected 1", s, in_ready);
      end
   endtask

   task automatic drain(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic set_mode(input logic [1:0] m);
      mode     = m;
      in_valid = 1'b0;
      tick();
   endtask

   task automatic clear_obs();
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      reset_n = 1'b0;
      m_reset();
      @(negedge clk_usb);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (out_byte !== 8'h00) begin n_err++; $display("FAIL reset_out_byte: got %h expected 00", out_byte); end
      n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b expected 1", idle); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_vec++; if (byte_count !== '0) begin n_err++; $display("FAIL reset_byte_count: got %0d expected 0", byte_count); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_mode8();
      clear_obs();
      out_ready = 1'b1;
      push(12'h123);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL m8_latency: out_valid %b expected 1", out_valid); end
      push(12'h456);
      drain(3);
      n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL m8_count: got %0d bytes expected 2", got_q.size()); end
      else begin
         n_vec++; if (got_q[0] !== 8'h12) begin n_err++; $display("FAIL m8_byte0: got %h expected 12", got_q[0]); end
         n_vec++; if (got_q[1] !== 8'h45) begin n_err++; $display("FAIL m8_byte1: got %h expected 45", got_q[1]); end
      end
      n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL m8_idle: got %b expected 1", idle); end
      n_vec++; if (byte_count !== 6'd2) begin n_err++; $display("FAIL m8_byte_count: got %0d expected 2", byte_count); end
   endtask

   task automatic test_mode12();
      logic [7:0] want [3];
      want = '{8'hAB, 8'hCD, 8'hEF};
      set_mode(2'b01);
      clear_obs();
      out_ready = 1'b1;
      push(12'hABC);
      push(12'hDEF);
      drain(4);
      n_vec++; if (got_q.size() != 3) begin n_err++; $display("FAIL m12_count: got %0d bytes expected 3", got_q.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_vec++; if (got_q[i] !== want[i]) begin n_err++; $display("FAIL m12_byte%0d: got %h expected %h", i, got_q[i], want[i]); end
         end
         n_vec++; if (got_cyc[2] - got_cyc[0] != 2) begin n_err++; $display("FAIL m12_consecutive: span %0d cycles expected 2", got_cyc[2] - got_cyc[0]); end
      end
   endtask

   task automatic test_flush();
      set_mode(2'b01);
      clear_obs();
      out_ready = 1'b1;
      push(12'h5A3);
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      drain(3);
      n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL flush_count: got %0d bytes expected 2", got_q.size()); end
      else begin
         n_vec++; if (got_q[0] !== 8'h5A) begin n_err++; $display("FAIL flush_byte0: got %h expected 5A", got_q[0]); end
         n_vec++; if (got_q[1] !== 8'h30) begin n_err++; $display("FAIL flush_byte1: got %h expected 30", got_q[1]); end
      end
      n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL flush_idle: got %b expected 1", idle); end
      // Flush with nothing pending must not create a byte.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_vec++; if (idle !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: idle %b out_valid %b expected 1 0", idle, out_valid); end
   endtask

   task automatic test_mode16();
      set_mode(2'b10);
      clear_obs();
      out_ready = 1'b0;
      push(12'hABC);
      in_valid = 1'b0;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL m16_in_ready: got %b expected 0", in_ready); end
      n_vec++; if (out_byte !== 8'h0A) begin n_err++; $display("FAIL m16_head: got %h expected 0A", out_byte); end
      out_ready = 1'b1;
      drain(3);
      n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL m16_count: got %0d bytes expected 2", got_q.size()); end
      else begin
         n_vec++; if (got_q[0] !== 8'h0A) begin n_err++; $display("FAIL m16_byte0: got %h expected 0A", got_q[0]); end
         n_vec++; if (got_q[1] !== 8'hBC) begin n_err++; $display("FAIL m16_byte1: got %h expected BC", got_q[1]); end
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      set_mode(2'b00);
      clear_obs();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(12'(i << 4));
      in_valid = 1'b0;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: in_ready %b expected 0", in_ready); end
      out_ready = 1'b1;
      for (int i = 3; i < 90; i++) push(12'(i << 4));
      drain(6);
      n_vec++; if (got_q.size() != 90) begin n_err++; $display("FAIL b2b_count: got %0d bytes expected 90", got_q.size()); end
      else begin
         for (int i = 0; i < 90; i++) begin
            if (got_q[i] !== 8'(i)) bad++;
            if (i > 0 && got_cyc[i] != got_cyc[i-1] + 1) bad++;
         end
         n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b_stream: %0d wrong or gapped bytes expected 0", bad); end
      end
      n_vec++; if (byte_count !== 6'(CMAX)) begin n_err++; $display("FAIL b2b_saturate: got %0d expected %0d", byte_count, CMAX); end
   endtask

   task automatic test_clear_count();
      out_ready = 1'b1;
      push(12'h123);
      in_valid    = 1'b0;
      clear_count = 1'b1;
      tick();
      clear_count = 1'b0;
      n_vec++; if (byte_count !== 6'd0) begin n_err++; $display("FAIL clear_wins: got %0d expected 0", byte_count); end
      push(12'h200);
      drain(2);
      n_vec++; if (byte_count !== 6'd1) begin n_err++; $display("FAIL clear_then_pop: got %0d expected 1", byte_count); end
   endtask

   task automatic test_reset_mid();
      set_mode(2'b00);
      clear_obs();
      out_ready = 1'b0;
      push(12'h111);
      push(12'h222);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      m_reset();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rstmid_idle: got %b expected 1", idle); end
      #1 reset_n = 1'b1;
      tick();
      out_ready = 1'b1;
      push(12'h777);
      drain(4);
      n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL rstmid_count: got %0d bytes expected 1", got_q.size()); end
      else begin
         n_vec++; if (got_q[0] !== 8'h77) begin n_err++; $display("FAIL rstmid_byte: got %h expected 77", got_q[0]); end
      end
   endtask

   task automatic test_random();
      int bad = 0;
      clear_obs();
      for (int c = 0; c < 3000; c++) begin
         in_valid    = ($urandom % 10) < 7;
         in_data     = 12'($urandom);
         out_ready   = ($urandom % 10) < 6;
         flush       = ($urandom % 10) == 0;
         clear_count = ($urandom % 20) == 0;
         if (($urandom % 16) == 0) mode = 2'($urandom);
         n_vec++; if (in_ready !== m_ready()) begin n_err++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, in_ready, m_ready()); end
         n_vec++; if (out_valid !== (m_q.size() >= 8)) begin n_err++; $display("FAIL rnd_out_valid c%0d: got %b expected %b", c, out_valid, m_q.size() >= 8); end
         n_vec++; if (idle !== (m_q.size() == 0)) begin n_err++; $display("FAIL rnd_idle c%0d: got %b expected %b", c, idle, m_q.size() == 0); end
         n_vec++; if (byte_count !== 6'(m_count)) begin n_err++; $display("FAIL rnd_byte_count c%0d: got %0d expected %0d", c, byte_count, m_count); end
         if (m_q.size() >= 8) begin
            n_vec++; if (out_byte !== m_front_byte()) begin n_err++; $display("FAIL rnd_out_byte c%0d: got %h expected %h", c, out_byte, m_front_byte()); end
         end
         tick();
      end
      in_valid    = 1'b0;
      clear_count = 1'b0;
      out_ready   = 1'b1;
      flush       = 1'b1;
      tick();
      flush = 1'b0;
      drain(6);
      n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_stream_len: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      else begin
         for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
         n_vec++; if (bad != 0) begin n_err++; $display("FAIL rnd_stream: %0d bytes differ expected 0", bad); end
      end
      n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rnd_final_idle: got %b expected 1", idle); end
   endtask

   initial begin
      reset_n     = 1'b0;
      mode        = 2'b00;
      in_data     = '0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      flush       = 1'b0;
      clear_count = 1'b0;
      test_reset();
      test_mode8();
      test_mode12();
      test_flush();
      test_mode16();
      test_back_to_back();
      test_clear_count();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
